// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation and sequencer state encodings, plus the
// 1-bit ALU slice function used by the serial sequencer and the combinational ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_SLT  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_NAND = 3'b101,
    ALU_NOR  = 3'b110,
    ALU_OR   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_SLTFIX = 2'b10,
    ST_DONE   = 2'b11
  } seq_state_e;

  // Operations that go through the adder and produce carry/overflow.
  function automatic logic is_arith(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  // Operations that add the inverted b operand with an initial carry of 1.
  function automatic logic is_subtract(input alu_op_e op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  // One bit of the ALU: returns {cout, result}. SUB/SLT invert b here.
  function automatic logic [1:0] alu_slice(input logic a, input logic b,
                                           input logic cin, input alu_op_e op);
    logic bb;
    logic r;
    logic c;
    bb = is_subtract(op) ? ~b : b;
    r  = 1'b0;
    c  = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT: begin
        r = a ^ bb ^ cin;
        c = (a & bb) | (cin & (a ^ bb));
      end
      ALU_XOR:  r = a ^ b;
      ALU_AND:  r = a & b;
      ALU_NAND: r = ~(a & b);
      ALU_NOR:  r = ~(a | b);
      ALU_OR:   r = a | b;
      default:  r = 1'b0;
    endcase
    return {c, r};
  endfunction

endpackage

// File: rtl/alu_seq_shiftreg.sv
// Loadable right-shift register: load has priority over shift, new bits
// enter at the MSB end so an LSB-first stream ends up in natural order.
module alu_seq_shiftreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  // Register: parallel load, else shift right by one inserting sin at the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: one shared 1-bit slice processes the operands
// LSB-first, one bit per clock, with a carry flip-flop and an SLT fix-up pass.
// Build option: ALU_SEQ_LOGIC_BYPASS_EN computes XOR/AND/NAND/NOR/OR
// word-parallel at accept and skips the serial pass (results unchanged).
module alu_serial_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only when idle and no done pulse is showing;
  // an accepted start raises busy from the next cycle through the done cycle
  // inclusive. done is a one-cycle pulse; result and flags are valid then and
  // held until the next accept. start at any other time is dropped.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  alu_op_e          op_in;
  alu_op_e          op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             done_q, carryout_q, overflow_q, zero_q;
  logic             accept, running, last_bit, bypass;
  logic             slice_res, slice_cout;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] logic_word;
  logic             res_load;
  logic [WIDTH-1:0] res_din;
  logic             unused_operand_msbs;

  assign op_in    = alu_op_e'(op);
  assign accept   = (state_q == ST_IDLE) && start && !done_q;
  assign running  = (state_q == ST_RUN);
  assign last_bit = running && (cnt_q == LAST_BIT);

  assign {slice_cout, slice_res} = alu_slice(a_sr[0], b_sr[0], carry_q, op_q);

`ifdef ALU_SEQ_LOGIC_BYPASS_EN
  // Word-parallel result for the pure logic operations, taken at accept.
  always_comb begin
    logic_word = '0;
    case (op_in)
      ALU_XOR:  logic_word = a ^ b;
      ALU_AND:  logic_word = a & b;
      ALU_NAND: logic_word = ~(a & b);
      ALU_NOR:  logic_word = ~(a | b);
      ALU_OR:   logic_word = a | b;
      default:  logic_word = '0;
    endcase
  end
  assign bypass = accept && !is_arith(op_in);
`else
  assign logic_word = '0;
  assign bypass     = 1'b0;
`endif

  // Result register load: bypass word at accept, or the SLT fix-up value.
  // A bypassed logic op passes through SLTFIX as a settle cycle but is not
  // rewritten there because op_q is not SLT.
  assign res_load = bypass || ((state_q == ST_SLTFIX) && (op_q == ALU_SLT));
  assign res_din  = bypass ? logic_word
                           : {{(WIDTH-1){1'b0}}, res_sr[WIDTH-1] ^ overflow_q};

  // Operand registers are consumed at the LSB only; the upper bits just shift.
  assign unused_operand_msbs = ^{a_sr[WIDTH-1:1], b_sr[WIDTH-1:1]};

  alu_seq_shiftreg #(.WIDTH(WIDTH)) u_a_sr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (running),
    .sin   (1'b0),
    .din   (a),
    .q     (a_sr)
  );

  alu_seq_shiftreg #(.WIDTH(WIDTH)) u_b_sr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (running),
    .sin   (1'b0),
    .din   (b),
    .q     (b_sr)
  );

  alu_seq_shiftreg #(.WIDTH(WIDTH)) u_res_sr (
    .clk   (clk),
    .reset (reset),
    .load  (res_load),
    .shift (running),
    .sin   (slice_res),
    .din   (res_din),
    .q     (res_sr)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE -> RUN -> (SLTFIX) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = bypass ? ST_SLTFIX : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_BIT) begin
          state_d = (op_q == ALU_SLT) ? ST_SLTFIX : ST_DONE;
        end
      end
      ST_SLTFIX: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Serial datapath control: op latch, bit counter, carry FF and arithmetic flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= ALU_ADD;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      op_q    <= op_in;
      cnt_q   <= '0;
      carry_q <= is_subtract(op_in);
      if (bypass) begin
        carryout_q <= 1'b0;
        overflow_q <= 1'b0;
      end
    end else if (running) begin
      cnt_q   <= cnt_q + 1'b1;
      carry_q <= slice_cout;
      if (last_bit) begin
        // carry_q still holds the carry into the MSB here.
        carryout_q <= is_arith(op_q) & slice_cout;
        overflow_q <= is_arith(op_q) & (carry_q ^ slice_cout);
      end
    end
  end

  // Completion outputs: done pulse and zero flag leave the DONE state together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        zero_q <= (res_sr == '0);
      end
    end
  end

  assign busy      = (state_q != ST_IDLE) || done_q;
  assign done      = done_q;
  assign result    = res_sr;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer (WIDTH=32): directed vector
// table, re-pulse and mid-run reset sequences, and random operations checked
// against an arithmetic reference model.
module tb_alu_serial_sequencer;
  import alu_pkg::*;

  localparam int W        = 32;
  localparam int MAX_WAIT = 40;
  localparam int NV       = 15;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carryout, overflow, zero;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int txn   = 0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_flag_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vecs[NV];

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (txn %0d): got %h, expected %h", name, txn, got, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each operation.
  function automatic void ref_model(input logic [2:0] op_i, input logic [W-1:0] x,
                                    input logic [W-1:0] y, output logic [W-1:0] r,
                                    output logic co, output logic ov, output logic z);
    longint sx, sy, ux, uy, sd;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    r  = '0;
    co = 1'b0;
    ov = 1'b0;
    case (op_i)
      3'd0: begin
        r  = x + y;
        co = (ux + uy) >= 64'sh1_0000_0000;
        sd = sx + sy;
        ov = (sd > SMAX) || (sd < SMIN);
      end
      3'd1, 3'd3: begin
        r  = (op_i == 3'd1) ? (x - y) : ((sx < sy) ? 32'd1 : 32'd0);
        co = (ux >= uy);
        sd = sx - sy;
        ov = (sd > SMAX) || (sd < SMIN);
      end
      3'd2: r = x ^ y;
      3'd4: r = x & y;
      3'd5: r = ~(x & y);
      3'd6: r = ~(x | y);
      default: r = x | y;
    endcase
    z = (r == '0);
  endfunction

  // Cycles from the accepting edge to the edge that raises done.
  function automatic int exp_latency(input logic [2:0] op_i);
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
    if (!(op_i inside {3'd0, 3'd1, 3'd3})) return 2;
`endif
    return (op_i == 3'd3) ? W + 2 : W + 1;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Driver + scoreboard for one operation. With repulse set, start is
  // re-asserted with new operands in cycle 5 and in the done cycle.
  task automatic run_op(input logic [2:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [W-1:0] er, input logic eco, input logic eov, input logic ez,
                        input bit repulse);
    int n;
    int lat;
    logic [W-1:0] exp_res;
    logic [2:0]   fl;
    txn++;
    lat = exp_latency(op_i);
    exp_q.push_back(er);
    exp_flag_q.push_back({eco, eov, ez});
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(negedge clk);
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    n = 0;
    while (n <= MAX_WAIT && !done) begin
      check("busy_while_running", busy, 1);
      start = repulse && (n == 5);
      if (start) begin
        op = 3'd1; a = $urandom; b = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    exp_res = exp_q.pop_front();
    fl      = exp_flag_q.pop_front();
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout (txn %0d): no done within %0d cycles, expected at %0d", txn, MAX_WAIT, lat);
    end else begin
      check("latency", n, lat);
      check("busy_in_done", busy, 1);
      check("result", result, exp_res);
      check("carryout", carryout, fl[2]);
      check("overflow", overflow, fl[1]);
      check("zero", zero, fl[0]);
      start = repulse;
      if (repulse) begin
        op = 3'd0; a = $urandom; b = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      check("done_single_pulse", done, 0);
      check("busy_after_done", busy, 0);
      check("result_held", result, exp_res);
      check("zero_held", zero, fl[0]);
    end
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb, rr;
    logic         rco, rov, rz;
    bit           seen;

    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;

    vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{ALU_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{ALU_SLT,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{ALU_NOR,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{ALU_XOR,  32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{ALU_AND,  32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{ALU_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{ALU_OR,   32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{ALU_OR,   32'h80000001, 32'h00F00000, 32'h80F00001, 1'b0, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_carryout", carryout, 0);
    check("reset_overflow", overflow, 0);
    check("reset_zero", zero, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].co, vecs[i].ov, vecs[i].z, 1'b0);
    end

    // start re-pulsed mid-run and in the done cycle: both ignored.
    run_op(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of RUN aborts without a done pulse.
    txn++;
    @(negedge clk);
    start = 1'b1; op = ALU_ADD; a = 32'h12345678; b = 32'h00000001;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_abort", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_carryout", carryout, 0);
    check("abort_overflow", overflow, 0);
    check("abort_zero", zero, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (MAX_WAIT) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("no_done_after_abort", seen, 0);
    run_op(ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
      ref_model(rop, ra, rb, rr, rco, rov, rz);
      run_op(rop, ra, rb, rr, rco, rov, rz, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
